// File: rtl/decryption_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decryption_pkg
// Description : Shared regfile addresses, cipher ids, status codes and FSM
//               encoding for the decryption config sequencer.
//               The readback states exist only when DECRYPTION_CFG_READBACK_EN
//               is defined.
// Revision    : 1.0  initial release
// ============================================================================
package decryption_pkg;

  localparam logic [7:0] ADDR_SELECT  = 8'h00;
  localparam logic [7:0] ADDR_CAESAR  = 8'h10;
  localparam logic [7:0] ADDR_SCYTALE = 8'h12;
  localparam logic [7:0] ADDR_ZIGZAG  = 8'h14;

  typedef enum logic [1:0] {
    CIPHER_CAESAR  = 2'd0,
    CIPHER_SCYTALE = 2'd1,
    CIPHER_ZIGZAG  = 2'd2,
    CIPHER_INVALID = 2'd3
  } cipher_t;

  typedef enum logic [1:0] {
    STATUS_OK         = 2'd0,
    STATUS_BAD_CIPHER = 2'd1,
    STATUS_REG_ERROR  = 2'd2,
    STATUS_TIMEOUT    = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_KEY   = 3'd1,
    ST_WAIT_KEY = 3'd2,
    ST_WR_SEL   = 3'd3,
    ST_WAIT_SEL = 3'd4,
`ifdef DECRYPTION_CFG_READBACK_EN
    ST_RD_SEL   = 3'd6,
    ST_WAIT_RD  = 3'd7,
`endif
    ST_RESP     = 3'd5
  } state_t;

  function automatic logic [7:0] key_addr(input cipher_t c);
    case (c)
      CIPHER_CAESAR:  key_addr = ADDR_CAESAR;
      CIPHER_SCYTALE: key_addr = ADDR_SCYTALE;
      CIPHER_ZIGZAG:  key_addr = ADDR_ZIGZAG;
      default:        key_addr = ADDR_SELECT;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decryption_cfg_timeout.sv
`default_nettype none
// ============================================================================
// Module      : decryption_cfg_timeout
// Description : Loadable down-counter; expired flags the last allowed cycle
//               of a regfile wait.
// Revision    : 1.0  initial release
// ============================================================================
module decryption_cfg_timeout #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= 8'(LIMIT);
    end else if (enable && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  // A count of one means this cycle is the last one without done.
  assign expired = (count == 8'd1);

endmodule
`default_nettype wire

// File: rtl/decryption_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : decryption_cfg_sequencer
// Description : Accepts one cipher/key command and programs the key and select
//               registers of decryption_regfile, then reports one status.
//               DECRYPTION_CFG_READBACK_EN adds a select readback check.
// Revision    : 1.0  initial release
// ============================================================================
module decryption_cfg_sequencer
  import decryption_pkg::*;
#(
  parameter int addr_width     = 8,
  parameter int reg_width      = 16,
  parameter int timeout_cycles = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_cipher,
  input  logic [reg_width-1:0]  cfg_key,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic                  busy,
  output logic [addr_width-1:0] addr,
  output logic                  read,
  output logic                  write,
  output logic [reg_width-1:0]  wdata,
  input  logic [reg_width-1:0]  rdata,
  input  logic                  done,
  input  logic                  error
);

  state_t  state, state_d;
  status_t status_q, status_d;
  cipher_t cipher_q;
  logic    tmo_load, tmo_enable, tmo_expired, in_wait;

`ifdef DECRYPTION_CFG_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^rdata[reg_width-1:2];
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata;
`endif

  // rst_n is active-high in spite of its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= ST_IDLE;
      status_q <= STATUS_OK;
      cipher_q <= CIPHER_CAESAR;
      addr     <= '0;
      wdata    <= '0;
    end else begin
      state    <= state_d;
      status_q <= status_d;
      if ((state == ST_IDLE) && cfg_valid) begin
        cipher_q <= cipher_t'(cfg_cipher);
      end
      case (state_d)
        ST_WR_KEY: begin
          addr  <= addr_width'(key_addr(cipher_t'(cfg_cipher)));
          wdata <= cfg_key;
        end
        ST_WR_SEL: begin
          addr  <= addr_width'(ADDR_SELECT);
          wdata <= reg_width'(cipher_q);
        end
`ifdef DECRYPTION_CFG_READBACK_EN
        ST_RD_SEL: addr <= addr_width'(ADDR_SELECT);
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state;
    status_d = status_q;
    case (state)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cipher_t'(cfg_cipher) == CIPHER_INVALID) begin
            state_d  = ST_RESP;
            status_d = STATUS_BAD_CIPHER;
          end else begin
            state_d = ST_WR_KEY;
          end
        end
      end
      ST_WR_KEY: state_d = ST_WAIT_KEY;
      ST_WAIT_KEY: begin
        if (done) begin
          if (error) begin
            state_d  = ST_RESP;
            status_d = STATUS_REG_ERROR;
          end else begin
            state_d = ST_WR_SEL;
          end
        end else if (tmo_expired) begin
          state_d  = ST_RESP;
          status_d = STATUS_TIMEOUT;
        end
      end
      ST_WR_SEL: state_d = ST_WAIT_SEL;
      ST_WAIT_SEL: begin
        if (done) begin
          if (error) begin
            state_d  = ST_RESP;
            status_d = STATUS_REG_ERROR;
          end else begin
`ifdef DECRYPTION_CFG_READBACK_EN
            state_d = ST_RD_SEL;
`else
            state_d  = ST_RESP;
            status_d = STATUS_OK;
`endif
          end
        end else if (tmo_expired) begin
          state_d  = ST_RESP;
          status_d = STATUS_TIMEOUT;
        end
      end
`ifdef DECRYPTION_CFG_READBACK_EN
      ST_RD_SEL: state_d = ST_WAIT_RD;
      ST_WAIT_RD: begin
        if (done) begin
          state_d  = ST_RESP;
          status_d = (error || (rdata[1:0] != cipher_q)) ? STATUS_REG_ERROR : STATUS_OK;
        end else if (tmo_expired) begin
          state_d  = ST_RESP;
          status_d = STATUS_TIMEOUT;
        end
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    rsp_valid  = (state == ST_RESP);
    rsp_status = status_q;
    write      = (state == ST_WR_KEY) || (state == ST_WR_SEL);
`ifdef DECRYPTION_CFG_READBACK_EN
    read       = (state == ST_RD_SEL);
    in_wait    = (state == ST_WAIT_KEY) || (state == ST_WAIT_SEL) || (state == ST_WAIT_RD);
    tmo_load   = write || read;
`else
    read       = 1'b0;
    in_wait    = (state == ST_WAIT_KEY) || (state == ST_WAIT_SEL);
    tmo_load   = write;
`endif
    tmo_enable = in_wait && !done;
  end

  // Every strobe state is followed by a wait, so the strobe cycle reloads.
  decryption_cfg_timeout #(
    .LIMIT (timeout_cycles)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst_n),
    .load    (tmo_load),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

endmodule
`default_nettype wire
